apb_master_ctrl: RTL and testbench



---
 rtl/apb_bridge_pkg.sv | 19 +
 rtl/apb_master_ctrl_if.sv | 34 +++
 rtl/apb_addr_decoder.sv | 22 ++
 rtl/apb_master_ctrl.sv | 102 ++++++++++
 tb/tb_apb_master_ctrl.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the AHB-APB bridge master-side controller.
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ENABLE = 2'd2,
    ERR    = 2'd3
  } apb_state_e;

  localparam int NSLV = 3;

  localparam logic [7:0] DFLT_SLV0_BASE = 8'h80;
  localparam logic [7:0] DFLT_SLV1_BASE = 8'h84;
  localparam logic [7:0] DFLT_SLV2_BASE = 8'h88;

  localparam logic [NSLV-1:0] PSEL_NONE = 3'b000;

endpackage

// File: rtl/apb_master_ctrl_if.sv
// Request, APB and response signals between the AHB-side pipeline, controller and APB slaves.
interface apb_master_ctrl_if
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic [DATA_W-1:0] Prdata;
  logic [NSLV-1:0]   Pselx;
  logic              Penable;
  logic              Pwrite;
  logic [ADDR_W-1:0] Paddr;
  logic [DATA_W-1:0] Pwdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, Prdata,
    output req_ready, Pselx, Penable, Pwrite, Paddr, Pwdata,
           rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, Prdata,
    input  req_ready, Pselx, Penable, Pwrite, Paddr, Pwdata,
           rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/apb_addr_decoder.sv
// Maps the top address byte to a one-hot APB slave select; miss flags unmapped space.
module apb_addr_decoder
  import apb_bridge_pkg::*;
#(
  parameter logic [7:0] SLV0_BASE = DFLT_SLV0_BASE,
  parameter logic [7:0] SLV1_BASE = DFLT_SLV1_BASE,
  parameter logic [7:0] SLV2_BASE = DFLT_SLV2_BASE
) (
  input  logic [7:0]      addr_hi,
  output logic [NSLV-1:0] sel,
  output logic            miss
);

  always_comb begin
    sel = PSEL_NONE;
    if (addr_hi == SLV0_BASE)      sel = 3'b001;
    else if (addr_hi == SLV1_BASE) sel = 3'b010;
    else if (addr_hi == SLV2_BASE) sel = 3'b100;
    miss = (sel == PSEL_NONE);
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB master sequencer: accepts one request, runs SETUP/ENABLE, returns a one-cycle response.
//  state  | meaning
//  IDLE   | no APB activity, ready for a request
//  SETUP  | Pselx driven, Penable low, not ready
//  ENABLE | Pselx held, Penable high, Prdata sampled at exit
//  ERR    | decode miss, no APB activity, error response next cycle
module apb_master_ctrl
  import apb_bridge_pkg::*;
#(
  parameter int         ADDR_W    = 32,
  parameter int         DATA_W    = 32,
  parameter logic [7:0] SLV0_BASE = DFLT_SLV0_BASE,
  parameter logic [7:0] SLV1_BASE = DFLT_SLV1_BASE,
  parameter logic [7:0] SLV2_BASE = DFLT_SLV2_BASE
) (
  input  logic           Hclk,
  input  logic           Hreset,
  apb_master_ctrl_if.master bus
);

  apb_state_e        state, state_nxt;
  logic [NSLV-1:0]   dec_sel, sel_q, psel_c;
  logic              dec_miss, accept, penable_c;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q, rsp_rdata_q;
  logic              pwrite_q, rsp_valid_q, rsp_err_q;

  apb_addr_decoder #(
    .SLV0_BASE (SLV0_BASE),
    .SLV1_BASE (SLV1_BASE),
    .SLV2_BASE (SLV2_BASE)
  ) u_dec (
    .addr_hi (bus.req_addr[ADDR_W-1 -: 8]),
    .sel     (dec_sel),
    .miss    (dec_miss)
  );

  // Held low during reset so nothing is accepted before the FSM is live.
  assign bus.req_ready = !Hreset && (state != SETUP);
  assign accept        = bus.req_valid && bus.req_ready;

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    psel_c    = PSEL_NONE;
    penable_c = 1'b0;
    case (state)
      SETUP: begin
        state_nxt = ENABLE;
        psel_c    = sel_q;
      end
      ENABLE: begin
        psel_c    = sel_q;
        penable_c = 1'b1;
      end
      default: ;
    endcase
    if (state != SETUP && accept) state_nxt = dec_miss ? ERR : SETUP;
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      sel_q       <= PSEL_NONE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= (state == ENABLE) || (state == ERR);
      if (state == ENABLE) begin
        rsp_rdata_q <= pwrite_q ? '0 : bus.Prdata;
        rsp_err_q   <= 1'b0;
      end else if (state == ERR) begin
        rsp_rdata_q <= '0;
        rsp_err_q   <= 1'b1;
      end
      // Address/data only move on a mapped accept to keep the APB bus quiet.
      if (accept && !dec_miss) begin
        sel_q    <= dec_sel;
        paddr_q  <= bus.req_addr;
        pwrite_q <= bus.req_write;
        pwdata_q <= bus.req_wdata;
      end
    end
  end

  assign bus.Pselx     = psel_c;
  assign bus.Penable   = penable_c;
  assign bus.Paddr     = paddr_q;
  assign bus.Pwrite    = pwrite_q;
  assign bus.Pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Scoreboard bench for apb_master_ctrl: directed cases plus randomized traffic against a memory model.
module tb_apb_master_ctrl;
  import apb_bridge_pkg::*;

  logic Hclk = 1'b0;
  logic Hreset = 1'b1;
  always #5 Hclk = ~Hclk;

  apb_master_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_master_ctrl #(
    .ADDR_W(32), .DATA_W(32),
    .SLV0_BASE(8'h80), .SLV1_BASE(8'h84), .SLV2_BASE(8'h88)
  ) dut (
    .Hclk   (Hclk),
    .Hreset (Hreset),
    .bus    (bus.master)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [31:0] ref_mem [NSLV][16];
  logic [31:0] slv_mem [NSLV][16];

  function automatic int sel_idx(logic [2:0] s);
    case (s)
      3'b010:  return 1;
      3'b100:  return 2;
      default: return 0;
    endcase
  endfunction

  // APB slave model: three 16-word memories, cleared by reset.
  always @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      for (int s = 0; s < NSLV; s++)
        for (int i = 0; i < 16; i++) slv_mem[s][i] <= '0;
    end else if (bus.Penable && bus.Pwrite && bus.Pselx != 3'b000) begin
      slv_mem[sel_idx(bus.Pselx)][bus.Paddr[5:2]] <= bus.Pwdata;
    end
  end
  assign bus.Prdata = slv_mem[sel_idx(bus.Pselx)][bus.Paddr[5:2]];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_ref();
    for (int s = 0; s < NSLV; s++)
      for (int i = 0; i < 16; i++) ref_mem[s][i] = '0;
  endtask

  // Reference model: what the accepted request must eventually return.
  task automatic ref_access(logic w, logic [31:0] a, logic [31:0] d);
    rsp_t r;
    int   s;
    s = -1;
    if (a[31:24] == 8'h80) s = 0;
    if (a[31:24] == 8'h84) s = 1;
    if (a[31:24] == 8'h88) s = 2;
    if (s < 0) begin
      r.rdata = '0; r.err = 1'b1;
    end else if (w) begin
      ref_mem[s][a[5:2]] = d;
      r.rdata = '0; r.err = 1'b0;
    end else begin
      r.rdata = ref_mem[s][a[5:2]]; r.err = 1'b0;
    end
    exp_q.push_back(r);
  endtask

  // Response monitor.
  always @(negedge Hclk) begin
    rsp_t e;
    if (bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response");
      end else begin
        e = exp_q.pop_front();
        check("rsp_rdata", bus.rsp_rdata, e.rdata);
        check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
      end
    end
  end

  task automatic to_drive();
    @(posedge Hclk);
    #1;
  endtask

  task automatic set_req(logic w, logic [31:0] a, logic [31:0] d);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
  endtask

  // Presents a request until accepted; returns 1ns after the accepting edge.
  task automatic issue(logic w, logic [31:0] a, logic [31:0] d);
    bit done;
    done = 1'b0;
    set_req(w, a, d);
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge Hclk);
      if (bus.req_ready) begin
        ref_access(w, a, d);
        done = 1'b1;
      end
      to_drive();
    end
    bus.req_valid = 1'b0;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL issue_timeout: got req_ready=0 for 20 cycles expected accept");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, d;
    logic [7:0]  tops [4];
    tops[0] = 8'h80; tops[1] = 8'h84; tops[2] = 8'h88; tops[3] = 8'h00;
    clear_ref();
    bus.req_valid = 1'b0; bus.req_write = 1'b0;
    bus.req_addr  = '0;   bus.req_wdata = '0;

    // Reset held with random request traffic.
    for (int c = 0; c < 5; c++) begin
      to_drive();
      set_req(1'($urandom), $urandom, $urandom);
      @(negedge Hclk);
      check("rst_ready", 32'(bus.req_ready), 32'd0);
      check("rst_pselx", 32'(bus.Pselx), 32'd0);
      check("rst_penable", 32'(bus.Penable), 32'd0);
      check("rst_paddr", bus.Paddr, 32'd0);
      check("rst_pwdata", bus.Pwdata, 32'd0);
      check("rst_misc", 32'({bus.Pwrite, bus.rsp_valid, bus.rsp_err}), 32'd0);
      check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    end
    to_drive();
    bus.req_valid = 1'b0;
    Hreset = 1'b0;
    @(negedge Hclk);
    check("post_rst_ready", 32'(bus.req_ready), 32'd1);
    check("post_rst_pselx", 32'(bus.Pselx), 32'd0);

    // Single write.
    to_drive();
    issue(1'b1, 32'h8000_0010, 32'hDEAD_BEEF);
    @(negedge Hclk);
    check("wr_setup_pselx", 32'(bus.Pselx), 32'h1);
    check("wr_setup_penable", 32'(bus.Penable), 32'd0);
    check("wr_setup_paddr", bus.Paddr, 32'h8000_0010);
    check("wr_setup_pwdata", bus.Pwdata, 32'hDEAD_BEEF);
    check("wr_setup_pwrite", 32'(bus.Pwrite), 32'd1);
    check("wr_setup_ready", 32'(bus.req_ready), 32'd0);
    @(negedge Hclk);
    check("wr_enable_penable", 32'(bus.Penable), 32'd1);
    check("wr_enable_pselx", 32'(bus.Pselx), 32'h1);
    @(negedge Hclk);
    check("wr_rsp_valid", 32'(bus.rsp_valid), 32'd1);

    // Single read of a word written first.
    to_drive();
    issue(1'b1, 32'h8400_0004, 32'h1234_5678);
    repeat (2) to_drive();
    issue(1'b0, 32'h8400_0004, 32'h0);
    @(negedge Hclk);
    check("rd_setup_pselx", 32'(bus.Pselx), 32'h2);
    check("rd_setup_pwrite", 32'(bus.Pwrite), 32'd0);
    @(negedge Hclk);
    check("rd_enable_prdata", bus.Prdata, 32'h1234_5678);
    @(negedge Hclk);
    check("rd_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("rd_rsp_rdata", bus.rsp_rdata, 32'h1234_5678);

    // Back-to-back write then read with req_valid held.
    to_drive();
    d = $urandom;
    set_req(1'b1, 32'h8800_0000, d);
    @(negedge Hclk);
    check("b2b_ready0", 32'(bus.req_ready), 32'd1);
    ref_access(1'b1, 32'h8800_0000, d);
    to_drive();
    set_req(1'b0, 32'h8000_0000, 32'h0);
    @(negedge Hclk);
    check("b2b_ready1", 32'(bus.req_ready), 32'd0);
    check("b2b_setup1_pselx", 32'(bus.Pselx), 32'h4);
    check("b2b_setup1_penable", 32'(bus.Penable), 32'd0);
    to_drive();
    @(negedge Hclk);
    check("b2b_ready2", 32'(bus.req_ready), 32'd1);
    check("b2b_enable1_pselx", 32'(bus.Pselx), 32'h4);
    check("b2b_enable1_penable", 32'(bus.Penable), 32'd1);
    ref_access(1'b0, 32'h8000_0000, 32'h0);
    to_drive();
    bus.req_valid = 1'b0;
    @(negedge Hclk);
    check("b2b_ready3", 32'(bus.req_ready), 32'd0);
    check("b2b_setup2_pselx", 32'(bus.Pselx), 32'h1);
    check("b2b_setup2_penable", 32'(bus.Penable), 32'd0);
    check("b2b_rsp1_valid", 32'(bus.rsp_valid), 32'd1);
    to_drive();
    @(negedge Hclk);
    check("b2b_ready4", 32'(bus.req_ready), 32'd1);
    check("b2b_enable2_pselx", 32'(bus.Pselx), 32'h1);
    check("b2b_enable2_penable", 32'(bus.Penable), 32'd1);
    check("b2b_gap_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge Hclk);
    check("b2b_rsp2_valid", 32'(bus.rsp_valid), 32'd1);

    // Decode miss.
    to_drive();
    issue(1'b1, 32'h9000_0000, $urandom);
    @(negedge Hclk);
    check("miss_pselx", 32'(bus.Pselx), 32'd0);
    check("miss_penable", 32'(bus.Penable), 32'd0);
    check("miss_paddr", bus.Paddr, 32'h8000_0000);
    @(negedge Hclk);
    check("miss_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("miss_paddr_kept", bus.Paddr, 32'h8000_0000);

    // Reset during ENABLE of a read.
    to_drive();
    issue(1'b0, 32'h8400_0004, 32'h0);
    to_drive();
    check("mid_rst_penable_before", 32'(bus.Penable), 32'd1);
    Hreset = 1'b1;
    #1;
    check("mid_rst_pselx", 32'(bus.Pselx), 32'd0);
    check("mid_rst_penable", 32'(bus.Penable), 32'd0);
    void'(exp_q.pop_back());
    clear_ref();
    repeat (3) begin
      @(negedge Hclk);
      check("mid_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    to_drive();
    Hreset = 1'b0;
    to_drive();
    issue(1'b0, 32'h8400_0004, 32'h0);
    repeat (3) to_drive();

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 2)) to_drive();
      a = $urandom;
      a[31:24] = tops[$urandom_range(0, 3)];
      issue(1'($urandom_range(0, 1)), a, $urandom);
    end

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge Hclk);
    check("drain_outstanding", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
